// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants: instruction/PC widths and the NOP encoding
// that decode sees whenever no fetched instruction is available.
package mips_pkg;

    localparam int INSTR_W = 32;
    localparam int PC_W    = 32;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/iq_ptr_ctr.sv
// Wrap-around pointer for the instruction queue: counts 0..DEPTH-1 and returns
// to 0, with a clear that beats increment.
module iq_ptr_ctr #(
    parameter int DEPTH = 4,
    parameter int W     = $clog2(DEPTH)
) (
    input  logic         clk_i,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] ptr_o
);

    localparam logic [W-1:0] LAST = W'(DEPTH - 1);

    logic [W-1:0] ptr_q;
    logic [W-1:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (clr_i) begin
            ptr_d = '0;
        end else if (inc_i) begin
            ptr_d = (ptr_q == LAST) ? '0 : ptr_q + W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        ptr_q <= ptr_d;
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/instr_queue.sv
// FIFO of fetched {pc, instr} pairs between instruction memory and decode,
// with a single-cycle flush for redirects and NOP presented when empty.
import mips_pkg::*;

module instr_queue #(
    parameter int                DATA_W = mips_pkg::INSTR_W,
    parameter int                PC_W   = mips_pkg::PC_W,
    parameter int                DEPTH  = 4,
    parameter logic [DATA_W-1:0] NOP    = mips_pkg::NOP_INSTR
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_W-1:0]          in_instr,
    input  logic [PC_W-1:0]            in_pc,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_instr,
    output logic [PC_W-1:0]            out_pc,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [DATA_W-1:0] instr_mem_q [DEPTH];
    logic [PC_W-1:0]   pc_mem_q    [DEPTH];
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_d;
    logic [PTR_W-1:0]  wp;
    logic [PTR_W-1:0]  rp;
    logic              push;
    logic              pop;
    logic              clr;

    // Handshake readiness comes from occupancy alone, so out_ready never reaches in_ready.
    assign in_ready  = (count_q != FULL_CNT);
    assign out_valid = (count_q != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign clr       = rst | flush;

    iq_ptr_ctr #(.DEPTH(DEPTH), .W(PTR_W)) u_wp (
        .clk_i (clk),
        .clr_i (clr),
        .inc_i (push),
        .ptr_o (wp)
    );

    iq_ptr_ctr #(.DEPTH(DEPTH), .W(PTR_W)) u_rp (
        .clk_i (clk),
        .clr_i (clr),
        .inc_i (pop),
        .ptr_o (rp)
    );

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        count_q <= count_d;
    end

    // Storage is never cleared; a flushed or reset entry is unreachable once count drops to zero.
    always_ff @(posedge clk) begin
        if (!clr && push) begin
            instr_mem_q[wp] <= in_instr;
            pc_mem_q[wp]    <= in_pc;
        end
    end

    assign out_instr = out_valid ? instr_mem_q[rp] : NOP;
    assign out_pc    = out_valid ? pc_mem_q[rp]    : '0;
    assign count     = count_q;

endmodule

// File: tb/tb_instr_queue.sv
// Directed self-checking bench for instr_queue: reset, fill, drain, concurrent
// push/pop with pointer wrap, flush and reset during activity.
module tb_instr_queue;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [2:0]  count;

    int nChecks;
    int nFails;

    instr_queue dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_instr  (in_instr),
        .in_pc     (in_pc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_pc    (out_pc),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle's inputs, then land 1 time unit after the rising edge.
    task automatic applyStimulus(input logic r, input logic f, input logic iv,
                                 input logic [31:0] ins, input logic [31:0] pc,
                                 input logic orr);
        rst       = r;
        flush     = f;
        in_valid  = iv;
        in_instr  = ins;
        in_pc     = pc;
        out_ready = orr;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        nChecks++;
        assert (observed === expected)
        else begin
            nFails++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    initial begin
        nChecks = 0;
        nFails  = 0;

        // Reset
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        checkOutput("reset_count",     32'(count), 32'd0);
        checkOutput("reset_in_ready",  32'(in_ready), 32'd1);
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_out_instr", out_instr, 32'h0);
        checkOutput("reset_out_pc",    out_pc, 32'h0);

        // No same-cycle bypass while empty
        in_valid = 1'b1;
        in_instr = 32'h8C01_0004;
        in_pc    = 32'h0;
        #1;
        checkOutput("no_bypass_valid", 32'(out_valid), 32'd0);
        checkOutput("no_bypass_instr", out_instr, 32'h0);

        // Fill
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 32'h8C01_0004 + 32'(4 * i), 32'(4 * i), 1'b0);
            checkOutput("fill_count", 32'(count), 32'(i + 1));
            checkOutput("fill_head",  out_instr, 32'h8C01_0004);
        end
        checkOutput("full_in_ready", 32'(in_ready), 32'd0);
        checkOutput("full_out_pc",   out_pc, 32'h0);

        applyStimulus(1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF, 32'h100, 1'b0);
        checkOutput("full_push_ignored_count", 32'(count), 32'd4);
        checkOutput("full_push_ignored_head",  out_instr, 32'h8C01_0004);

        // Drain
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checkOutput("drain_pc",    out_pc, 32'(4 * i));
            checkOutput("drain_instr", out_instr, 32'h8C01_0004 + 32'(4 * i));
            applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        end
        checkOutput("drained_valid", 32'(out_valid), 32'd0);
        checkOutput("drained_instr", out_instr, 32'h0);
        checkOutput("drained_pc",    out_pc, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        checkOutput("empty_pop_ignored", 32'(count), 32'd0);

        // Concurrent push/pop at count 2, pointers wrap
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h1000_0200, 32'h200, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h1000_0204, 32'h204, 1'b0);
        checkOutput("conc_start_count", 32'(count), 32'd2);
        for (int k = 0; k < 10; k++) begin
            checkOutput("conc_head_pc",    out_pc, 32'h200 + 32'(4 * k));
            checkOutput("conc_head_instr", out_instr, 32'h1000_0200 + 32'(4 * k));
            applyStimulus(1'b0, 1'b0, 1'b1, 32'h1000_0208 + 32'(4 * k), 32'h208 + 32'(4 * k), 1'b1);
            checkOutput("conc_count", 32'(count), 32'd2);
        end
        checkOutput("conc_tail0_pc", out_pc, 32'h228);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        checkOutput("conc_tail1_pc", out_pc, 32'h22C);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        checkOutput("conc_empty", 32'(out_valid), 32'd0);

        // Flush with same-cycle push and pop
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 32'h2000_0300 + 32'(4 * i), 32'h300 + 32'(4 * i), 1'b0);
        end
        checkOutput("preflush_count", 32'(count), 32'd3);
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h2000_0400, 32'h400, 1'b1);
        checkOutput("flush_count", 32'(count), 32'd0);
        checkOutput("flush_valid", 32'(out_valid), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        checkOutput("flush_push_absent", 32'(count), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h2000_0500, 32'h500, 1'b0);
        checkOutput("postflush_pc", out_pc, 32'h500);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);

        // Reset mid-operation with push and flush asserted
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 32'h3000_0600 + 32'(4 * i), 32'h600 + 32'(4 * i), 1'b0);
        end
        checkOutput("prereset_count", 32'(count), 32'd4);
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h3000_0700, 32'h700, 1'b1);
        checkOutput("midreset_count",    32'(count), 32'd0);
        checkOutput("midreset_in_ready", 32'(in_ready), 32'd1);
        checkOutput("midreset_valid",    32'(out_valid), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'hABCD_0001, 32'h800, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        checkOutput("postreset_valid", 32'(out_valid), 32'd1);
        checkOutput("postreset_pc",    out_pc, 32'h800);
        checkOutput("postreset_instr", out_instr, 32'hABCD_0001);
        checkOutput("postreset_count", 32'(count), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
